// File: rtl/wb_arbiter2_pkg.sv
// Shared state and grant encodings for the two-master Wishbone arbiter.
// Used by wb_arbiter2 and wb_arb_pick.
package wb_arb_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_OWN0 = ST_OWN0,
    S_OWN1 = ST_OWN1
  } arb_state_e;

  // Maps a one-hot winner onto the ownership state it leads to.
  function automatic arb_state_e state_for(input logic [1:0] gnt);
    case (gnt)
      GNT_M0:  state_for = S_OWN0;
      GNT_M1:  state_for = S_OWN1;
      default: state_for = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter2_pick.sv
// Arbitration policy: picks a one-hot winner from the two cyc requests.
// WB_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise m0 wins ties.
module wb_arb_pick
  import wb_arb_defs::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] winner
);

`ifndef WB_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    winner = GNT_NONE;
    case (req)
      2'b01: winner = GNT_M0;
      2'b10: winner = GNT_M1;
      2'b11: begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        // last_owner high means m1 was the most recent owner.
        winner = last_owner ? GNT_M0 : GNT_M1;
`else
        winner = GNT_M0;
`endif
      end
      default: winner = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter with per-cycle grant and
// outstanding-ack tracking. Tie policy set by WB_ARB_ROUND_ROBIN_EN.
module wb_arbiter2
  import wb_arb_defs::*;
#(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int MAX_OUT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_data,
  output logic          o_m0_stall,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_data,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_data,
  output logic          o_m1_stall,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_data,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  input  logic          i_s_stall,
  input  logic          i_s_ack,
  input  logic [DW-1:0] i_s_data,
  output logic [1:0]    o_grant,
  output logic [1:0]    o_dbg_state
);

  // Handshake: a request is issued on a cycle where o_s_stb is high and
  // i_s_stall is low; every issued request is answered by exactly one
  // i_s_ack on a later cycle, and an ack with nothing outstanding is ignored.

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_m1_q, last_m1_d;

  logic [1:0]    winner;
  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic          owning, full, cnt_nz;
  logic          issue, ack_ok, release_bus;

  wb_arb_pick u_pick (
    .req        ({i_m1_cyc, i_m0_cyc}),
    .last_owner (last_m1_q),
    .winner     (winner)
  );

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    case (state_q)
      S_OWN0: begin
        own_cyc  = i_m0_cyc;
        own_stb  = i_m0_stb;
        own_we   = i_m0_we;
        own_addr = i_m0_addr;
        own_data = i_m0_data;
      end
      S_OWN1: begin
        own_cyc  = i_m1_cyc;
        own_stb  = i_m1_stb;
        own_we   = i_m1_we;
        own_addr = i_m1_addr;
        own_data = i_m1_data;
      end
      default: ;
    endcase
  end

  assign owning = (state_q != S_IDLE);
  assign full   = (cnt_q == CNT_MAX);
  assign cnt_nz = (cnt_q != '0);

  assign o_s_stb  = owning & own_cyc & own_stb & ~full;
  assign o_s_we   = own_we;
  assign o_s_addr = own_addr;
  assign o_s_data = own_data;

  assign issue  = o_s_stb & ~i_s_stall;
  assign ack_ok = i_s_ack & cnt_nz;

  // The owner lets go only once its cyc is down and no response is in flight
  // after this cycle; an ack arriving after cyc drops is drained, not routed.
  assign release_bus = owning & ~own_cyc &
                       (~cnt_nz | ((cnt_q == CNT_ONE) & i_s_ack));

  assign o_m0_stall = (state_q == S_OWN0) ? (i_s_stall | full) : 1'b1;
  assign o_m1_stall = (state_q == S_OWN1) ? (i_s_stall | full) : 1'b1;
  assign o_m0_ack   = (state_q == S_OWN0) & ack_ok & i_m0_cyc;
  assign o_m1_ack   = (state_q == S_OWN1) & ack_ok & i_m1_cyc;
  assign o_m0_data  = o_m0_ack ? i_s_data : '0;
  assign o_m1_data  = o_m1_ack ? i_s_data : '0;

  always_comb begin
    o_grant = GNT_NONE;
    case (state_q)
      S_OWN0:  o_grant = GNT_M0;
      S_OWN1:  o_grant = GNT_M1;
      default: o_grant = GNT_NONE;
    endcase
  end

  assign o_dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    cnt_d     = cnt_q;

    if (issue && !ack_ok) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!issue && ack_ok) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    // At release the owner's cyc is low, so the picker sees only the other
    // master and a waiting requester is handed the bus with no idle bubble.
    case (state_q)
      S_IDLE: begin
        if (winner != GNT_NONE) begin
          state_d   = state_for(winner);
          last_m1_d = (winner == GNT_M1);
        end
      end
      S_OWN0, S_OWN1: begin
        if (release_bus) begin
          state_d = state_for(winner);
          if (winner != GNT_NONE) begin
            last_m1_d = (winner == GNT_M1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_m1_q <= last_m1_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios followed by randomized traffic
// from both masters against a block-RAM style slave and a memory scoreboard.
module tb_wb_arbiter2;
  import wb_arb_defs::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MAX_OUT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- master drive ----------------
  logic          mc [2];
  logic          ms [2];
  logic          mw [2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] md [2];

  logic [1:0]    m_stall, m_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_stall, s_ack;
  logic [DW-1:0] s_rdata;
  logic [1:0]    grant, dbg_state;

  wb_arbiter2 #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_m0_cyc    (mc[0]),
    .i_m0_stb    (ms[0]),
    .i_m0_we     (mw[0]),
    .i_m0_addr   (ma[0]),
    .i_m0_data   (md[0]),
    .o_m0_stall  (m_stall[0]),
    .o_m0_ack    (m_ack[0]),
    .o_m0_data   (m0_rdata),
    .i_m1_cyc    (mc[1]),
    .i_m1_stb    (ms[1]),
    .i_m1_we     (mw[1]),
    .i_m1_addr   (ma[1]),
    .i_m1_data   (md[1]),
    .o_m1_stall  (m_stall[1]),
    .o_m1_ack    (m_ack[1]),
    .o_m1_data   (m1_rdata),
    .o_s_stb     (s_stb),
    .o_s_we      (s_we),
    .o_s_addr    (s_addr),
    .o_s_data    (s_wdata),
    .i_s_stall   (s_stall),
    .i_s_ack     (s_ack),
    .i_s_data    (s_rdata),
    .o_grant     (grant),
    .o_dbg_state (dbg_state)
  );

  // ---------------- slave: memory with ack latency lat (1..3) ----------------
  int            lat = 1;
  logic          stray = 1'b0;
  logic [DW-1:0] stray_data = '0;
  logic          pv [4] = '{default: 1'b0};
  logic [DW-1:0] pd [4] = '{default: '0};
  logic [DW-1:0] smem [64] = '{default: '0};

  assign s_ack   = pv[lat-1] | stray;
  assign s_rdata = stray ? stray_data : (pv[lat-1] ? pd[lat-1] : '0);

  always @(posedge clk) begin
    for (int k = 3; k > 0; k--) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    pv[0] <= s_stb && !s_stall;
    pd[0] <= smem[s_addr];
    if (s_stb && !s_stall && s_we) smem[s_addr] <= s_wdata;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW:0]   exp_q0[$];
  logic [DW:0]   exp_q1[$];
  logic [DW-1:0] ref_mem [64];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},    grant,      GNT_NONE);
    chk({tag, "_stall0"}, m_stall[0], 1);
    chk({tag, "_stall1"}, m_stall[1], 1);
    chk({tag, "_ack0"},   m_ack[0],   0);
    chk({tag, "_ack1"},   m_ack[1],   0);
    chk({tag, "_data0"},  m0_rdata,   0);
    chk({tag, "_data1"},  m1_rdata,   0);
    chk({tag, "_sstb"},   s_stb,      0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mc[m] = cyc; ms[m] = stb; mw[m] = we; ma[m] = addr; md[m] = data;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- random-phase master state ----------------
  bit   act [2];
  int   rem [2];
  int   outst [2];
  logic last_m1_model;
  logic [1:0] exp_gnt;
  logic [DW:0] ent;
  logic [DW-1:0] rd;

  initial begin
    for (int m = 0; m < 2; m++) set_m(m, 0, 0, 0, '0, '0);
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    s_stall = 1'b0;

    // reset state
    step(); step(); settle();
    chk_idle("rst");
    chk("rst_state", dbg_state, ST_IDLE);

    // m0 alone: write then read addr 5
    step(); reset = 1'b0; set_m(0, 1, 1, 1, 6'd5, 32'hDEADBEEF); settle();
    chk("t1_gnt_lat", grant, GNT_NONE);
    chk("t1_stall_lat", m_stall[0], 1);
    step(); settle();
    chk("t1_gnt", grant, GNT_M0);
    chk("t1_stall0", m_stall[0], 0);
    chk("t1_sstb", s_stb, 1);
    chk("t1_swe", s_we, 1);
    chk("t1_saddr", s_addr, 5);
    chk("t1_sdata", s_wdata, 32'hDEADBEEF);
    chk("t1_stall1_a", m_stall[1], 1);
    step(); set_m(0, 1, 1, 0, 6'd5, '0); settle();
    chk("t1_wr_ack", m_ack[0], 1);
    chk("t1_stall1_b", m_stall[1], 1);
    step(); set_m(0, 1, 0, 0, '0, '0); settle();
    chk("t1_rd_ack", m_ack[0], 1);
    chk("t1_rd_data", m0_rdata, 32'hDEADBEEF);
    chk("t1_stall1_c", m_stall[1], 1);
    step(); set_m(0, 0, 0, 0, '0, '0); settle();
    chk("t1_hold", grant, GNT_M0);
    step(); settle();
    chk_idle("t1_end");
    ref_mem[5] = 32'hDEADBEEF;

    // simultaneous request right after reset (last owner = m1)
    step(); reset = 1'b1; step(); settle();
    chk_idle("t2_rst");
    step(); reset = 1'b0; set_m(0, 1, 0, 0, '0, '0); set_m(1, 1, 0, 0, '0, '0); settle();
    chk("t2_gnt_lat", grant, GNT_NONE);
    step(); settle();
    chk("t2_tie", grant, GNT_M0);
    chk("t2_stall1", m_stall[1], 1);
    step(); set_m(0, 0, 0, 0, '0, '0); settle();
    chk("t2_release", grant, GNT_M0);
    step(); settle();
    chk("t2_handoff", grant, GNT_M1);
    chk("t2_state", dbg_state, ST_OWN1);
    chk("t2_m1_stall", m_stall[1], 0);
    chk("t2_m0_stall", m_stall[0], 1);
    step(); set_m(1, 0, 0, 0, '0, '0); settle();
    step(); settle();
    chk("t2_idle", grant, GNT_NONE);

    // outstanding limit with ack latency 3
    lat = 3;
    step(); set_m(0, 1, 1, 0, 6'd5, '0); settle();
    chk("t3_gnt_lat", grant, GNT_NONE);
    step(); settle();
    chk("t3_gnt", grant, GNT_M0);
    chk("t3_s1_stall", m_stall[0], 0);
    chk("t3_s1_stb", s_stb, 1);
    step(); settle();
    chk("t3_s2_stall", m_stall[0], 0);
    chk("t3_s2_stb", s_stb, 1);
    step(); settle();
    chk("t3_full_stall", m_stall[0], 1);
    chk("t3_full_stb", s_stb, 0);
    chk("t3_full_ack", m_ack[0], 0);
    step(); settle();
    chk("t3_ack1", m_ack[0], 1);
    chk("t3_ack1_data", m0_rdata, 32'hDEADBEEF);
    chk("t3_ack1_stall", m_stall[0], 1);
    chk("t3_ack1_stb", s_stb, 0);
    step(); settle();
    chk("t3_reopen_stall", m_stall[0], 0);
    chk("t3_reopen_stb", s_stb, 1);
    chk("t3_ack2", m_ack[0], 1);

    // drain: m0 drops cyc with one response in flight, m1 waiting
    step(); set_m(0, 0, 0, 0, '0, '0); set_m(1, 1, 0, 0, '0, '0); settle();
    chk("t4_hold_a", grant, GNT_M0);
    chk("t4_ack0_a", m_ack[0], 0);
    chk("t4_ack1_a", m_ack[1], 0);
    step(); settle();
    chk("t4_hold_b", grant, GNT_M0);
    chk("t4_m1_wait", m_stall[1], 1);
    step(); settle();
    chk("t4_drain_gnt", grant, GNT_M0);
    chk("t4_drain_ack0", m_ack[0], 0);
    chk("t4_drain_ack1", m_ack[1], 0);
    chk("t4_drain_data0", m0_rdata, 0);
    step(); set_m(1, 1, 1, 1, 6'd9, 32'hCAFEF00D); settle();
    chk("t4_gnt", grant, GNT_M1);
    chk("t4_m1_stall", m_stall[1], 0);
    ref_mem[9] = 32'hCAFEF00D;

    // reset while OWN1 has one response in flight
    step(); set_m(1, 1, 0, 0, '0, '0); reset = 1'b1; settle();
    chk("t5_pre", grant, GNT_M1);
    step(); reset = 1'b0; set_m(1, 0, 0, 0, '0, '0); settle();
    chk_idle("t5_reset");
    step(); settle();
    chk_idle("t5_late_ack");
    step(); set_m(0, 1, 1, 0, 6'd5, '0); settle();
    chk("t5_gnt_lat", grant, GNT_NONE);
    step(); stray = 1'b1; stray_data = 32'h12345678; settle();
    chk("t5_gnt", grant, GNT_M0);
    chk("t5_stray_ack", m_ack[0], 0);
    chk("t5_stray_data", m0_rdata, 0);
    chk("t5_s1_stall", m_stall[0], 0);
    step(); stray = 1'b0; settle();
    chk("t5_cnt_clear", m_stall[0], 0);
    chk("t5_s2_stb", s_stb, 1);
    step(); set_m(0, 1, 0, 0, '0, '0); settle();
    chk("t5_full", m_stall[0], 1);
    step(); settle();
    chk("t5_ack_a", m_ack[0], 1);
    chk("t5_data_a", m0_rdata, 32'hDEADBEEF);
    step(); settle();
    chk("t5_ack_b", m_ack[0], 1);
    chk("t5_data_b", m0_rdata, 32'hDEADBEEF);
    step(); set_m(0, 0, 0, 0, '0, '0); settle();
    chk("t5_release", grant, GNT_M0);
    step(); settle();
    chk_idle("t5_end");

    // tie arbitration over 8 bursts from idle; last owner is m0 here
    lat = 1;
    last_m1_model = 1'b0;
    for (int b = 0; b < 8; b++) begin
      step(); set_m(0, 1, 0, 0, '0, '0); set_m(1, 1, 0, 0, '0, '0); settle();
      chk("rr_lat", grant, GNT_NONE);
      step(); settle();
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_gnt = last_m1_model ? GNT_M0 : GNT_M1;
`else
      exp_gnt = GNT_M0;
`endif
      chk("rr_burst_gnt", grant, exp_gnt);
      last_m1_model = (exp_gnt == GNT_M1);
      step(); settle();
      step(); set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0); settle();
      chk("rr_burst_hold", grant, exp_gnt);
      step(); settle();
      chk("rr_burst_idle", grant, GNT_NONE);
    end

    // randomized traffic from both masters
    lat = 2;
    for (int m = 0; m < 2; m++) begin act[m] = 0; rem[m] = 0; outst[m] = 0; end
    for (int n = 0; n < 1800; n++) begin
      step();
      s_stall = ($urandom_range(0, 9) < 3);
      for (int m = 0; m < 2; m++) begin
        if (act[m] && rem[m] == 0 && outst[m] == 0) begin
          act[m] = 0;
        end else if (!act[m] && n < 1500 && $urandom_range(0, 3) == 0) begin
          act[m] = 1;
          rem[m] = $urandom_range(1, 4);
        end
        set_m(m, act[m], act[m] && rem[m] > 0 && $urandom_range(0, 2) != 0,
              1'($urandom_range(0, 1)), AW'($urandom_range(16, 63)), $urandom);
      end
      settle();
      chk("rnd_gnt_legal", grant == 2'b11, 0);
      if (grant == GNT_M0) begin
        chk("rnd_m1_blocked", m_stall[1], 1);
        chk("rnd_m1_noack", m_ack[1], 0);
      end else if (grant == GNT_M1) begin
        chk("rnd_m0_blocked", m_stall[0], 1);
        chk("rnd_m0_noack", m_ack[0], 0);
      end
      for (int m = 0; m < 2; m++) begin
        rd = (m == 0) ? m0_rdata : m1_rdata;
        if (m_ack[m]) begin
          if ((m == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk("rnd_ack_unexpected", m_ack[m], 0);
          end else begin
            ent = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            outst[m]--;
            if (ent[DW]) chk("rnd_rd_data", rd, ent[DW-1:0]);
          end
        end else begin
          chk("rnd_quiet_data", rd, 0);
        end
        if (ms[m] && !m_stall[m]) begin
          if (mw[m]) begin
            ref_mem[ma[m]] = md[m];
            ent = {1'b0, md[m]};
          end else begin
            ent = {1'b1, ref_mem[ma[m]]};
          end
          if (m == 0) exp_q0.push_back(ent); else exp_q1.push_back(ent);
          outst[m]++;
          rem[m]--;
        end
      end
    end
    chk("rnd_q0_drained", exp_q0.size(), 0);
    chk("rnd_q1_drained", exp_q1.size(), 0);
    chk("rnd_m0_done", act[0], 0);
    chk("rnd_m1_done", act[1], 0);
    s_stall = 1'b0;
    for (int m = 0; m < 2; m++) set_m(m, 0, 0, 0, '0, '0);
    step(); step(); settle();
    chk_idle("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
